// File: rtl/bch_syndrome_serial_pkg.sv
// Shared parameters, types and GF(2^m) helpers for the serial BCH syndrome generator.
package bch_syndrome_serial_pkg;

    localparam int unsigned M      = 4;
    localparam int unsigned KMax   = 5;
    localparam int unsigned D      = 7;
    localparam int unsigned N      = 15;
    localparam int unsigned IrrPol = 19;
    localparam int unsigned T      = (D - 1) / 2;
    localparam int unsigned T2     = 2 * T;
    localparam int unsigned PtrW   = 4;

    typedef logic [M-1:0]    data_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef data_t [1:T]     odd_t;
    typedef data_t [1:T2]    syn_t;

    function automatic int unsigned clogb2(input int unsigned x);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < x) r++;
        return r;
    endfunction

    localparam int unsigned CntW = clogb2(N + 1);

    // Shift-and-add multiply, reducing by the primitive polynomial each step.
    function automatic data_t gf_mult_a_by_b(input data_t a, input data_t b);
        data_t p;
        data_t s;
        p = '0;
        s = a;
        for (int i = 0; i < int'(M); i++) begin
            if (b[i]) p = p ^ s;
            s = s[M-1] ? ((s << 1) ^ data_t'(IrrPol)) : (s << 1);
        end
        return p;
    endfunction

    function automatic syn_t gen_alpha_tab();
        syn_t  tab;
        data_t a;
        a = data_t'(1);
        for (int i = 1; i <= int'(T2); i++) begin
            a      = gf_mult_a_by_b(a, data_t'(2));
            tab[i] = a;
        end
        return tab;
    endfunction

    localparam syn_t AlphaTab = gen_alpha_tab();

endpackage

// File: rtl/bch_syndrome_serial_expand.sv
// Expands odd syndromes to the full S_1..S_t2 set by GF squaring, plus zero detect.
module bch_syndrome_expand
    import bch_syndrome_serial_pkg::*;
(
    input  odd_t odd_i,
    output syn_t syn_o,
    output logic zero_o
);

    syn_t full;

    // S_2j = S_j^2 in characteristic 2; lower indices are always filled first.
    always_comb begin
        full = '0;
        for (int i = 1; i <= int'(T2); i++) begin
            if (i % 2 == 1) full[i] = odd_i[(i + 1) / 2];
            else            full[i] = gf_mult_a_by_b(full[i / 2], full[i / 2]);
        end
    end

    assign syn_o  = full;
    assign zero_o = (full == '0);

endmodule

// File: rtl/bch_syndrome_serial.sv
// Bit-serial BCH syndrome generator: Horner accumulators for odd syndromes, then a
// hold stage and an output stage that squares out the even syndromes.
module bch_syndrome_serial
    import bch_syndrome_serial_pkg::*;
(
    input  logic iclk,
    input  logic ireset,
    input  logic iclkena,
    input  logic ival,
    input  logic isop,
    input  logic ieop,
    input  logic idat,
    input  ptr_t iptr,
    output logic osyndrome_val,
    output ptr_t osyndrome_ptr,
    output syn_t osyndrome,
    output logic ozero,
    output logic olen_err
);

    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] CntN   = CntW'(N);

    odd_t            acc_q, acc_d, acc_step;
    logic            active_q, active_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ptr_t            ptr_q, ptr_d;

    odd_t            hold_q, hold_d;
    ptr_t            hold_ptr_q, hold_ptr_d;
    logic            hold_len_q, hold_len_d;
    logic            hold_val_q, hold_val_d;

    syn_t            syn_full, out_syn_q;
    logic            syn_zero, out_zero_q, out_len_q, out_val_q;
    ptr_t            out_ptr_q;

    // Constant multiply by alpha^(2j-1); idat enters as the new lowest coefficient.
    always_comb begin
        for (int j = 1; j <= int'(T); j++) begin
            acc_step[j] = gf_mult_a_by_b(acc_q[j], AlphaTab[2*j-1]) ^ data_t'(idat);
        end
    end

    always_comb begin
        acc_d      = acc_q;
        active_d   = active_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        hold_ptr_d = hold_ptr_q;
        hold_len_d = hold_len_q;
        hold_val_d = 1'b0;
        if (ival) begin
            if (isop) begin
                for (int j = 1; j <= int'(T); j++) acc_d[j] = data_t'(idat);
                cnt_d    = CntW'(1);
                ptr_d    = iptr;
                active_d = !ieop;
            end else if (active_q) begin
                acc_d = acc_step;
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
                if (ieop) active_d = 1'b0;
            end
            if (ieop && (isop || active_q)) begin
                hold_d     = acc_d;
                hold_ptr_d = ptr_d;
                hold_len_d = (cnt_d != CntN);
                hold_val_d = 1'b1;
            end
        end
    end

    bch_syndrome_expand u_expand (
        .odd_i  (hold_q),
        .syn_o  (syn_full),
        .zero_o (syn_zero)
    );

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            acc_q      <= '0;
            active_q   <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            hold_ptr_q <= '0;
            hold_len_q <= 1'b0;
            hold_val_q <= 1'b0;
            out_syn_q  <= '0;
            out_zero_q <= 1'b0;
            out_len_q  <= 1'b0;
            out_ptr_q  <= '0;
            out_val_q  <= 1'b0;
        end else if (iclkena) begin
            acc_q      <= acc_d;
            active_q   <= active_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            hold_ptr_q <= hold_ptr_d;
            hold_len_q <= hold_len_d;
            hold_val_q <= hold_val_d;
            out_val_q  <= hold_val_q;
            if (hold_val_q) begin
                out_syn_q  <= syn_full;
                out_zero_q <= syn_zero;
                out_len_q  <= hold_len_q;
                out_ptr_q  <= hold_ptr_q;
            end
        end
    end

    assign osyndrome_val = out_val_q;
    assign osyndrome_ptr = out_ptr_q;
    assign osyndrome     = out_syn_q;
    assign ozero         = out_zero_q;
    assign olen_err      = out_len_q;

endmodule

// File: tb/tb_bch_syndrome_serial.sv
// Self-checking bench for bch_syndrome_serial: directed spec cases plus randomized frames
// checked against a direct polynomial-evaluation model r(alpha^i).
module tb_bch_syndrome_serial;
    import bch_syndrome_serial_pkg::*;

    logic iclk = 1'b0;
    logic ireset, iclkena, ival, isop, ieop, idat;
    ptr_t iptr;
    logic osyndrome_val, ozero, olen_err;
    ptr_t osyndrome_ptr;
    syn_t osyndrome;

    bch_syndrome_serial dut (
        .iclk          (iclk),
        .ireset        (ireset),
        .iclkena       (iclkena),
        .ival          (ival),
        .isop          (isop),
        .ieop          (ieop),
        .idat          (idat),
        .iptr          (iptr),
        .osyndrome_val (osyndrome_val),
        .osyndrome_ptr (osyndrome_ptr),
        .osyndrome     (osyndrome),
        .ozero         (ozero),
        .olen_err      (olen_err)
    );

    always #5 iclk = ~iclk;

    typedef struct packed {
        logic [3:0]  ptr;
        logic        zero;
        logic        len_err;
        logic [23:0] syn;   // S1 in [3:0] ... S6 in [23:20]
    } res_t;

    res_t act_q[$];
    int   act_cyc[$];
    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic ena_edge = 1'b0;

    // alpha^e by repeated multiplication by x modulo x^4+x+1
    function automatic int gexp(input int e);
        int v;
        v = 1;
        for (int k = 0; k < e % 15; k++) begin
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 19;
        end
        return v;
    endfunction

    // bits[j] is the coefficient of x^j; S_i = sum_j r_j * alpha^(i*j)
    function automatic res_t ref_res(input logic [31:0] bits, input int len, input logic [3:0] p);
        res_t r;
        r.syn = '0;
        for (int i = 1; i <= 6; i++)
            for (int j = 0; j < len; j++)
                if (bits[j]) r.syn[4*(i-1) +: 4] = r.syn[4*(i-1) +: 4] ^ 4'(gexp(i * j));
        r.zero    = (r.syn == 24'h0);
        r.len_err = (len != 15);
        r.ptr     = p;
        return r;
    endfunction

    always @(posedge iclk) begin
        ena_edge <= iclkena;
        cyc      <= cyc + 1;
    end

    // A result is new only if the edge that produced it was enabled.
    always @(negedge iclk) begin
        if (osyndrome_val && ena_edge) begin
            res_t r;
            r.ptr     = osyndrome_ptr;
            r.zero    = ozero;
            r.len_err = olen_err;
            for (int i = 1; i <= 6; i++) r.syn[4*(i-1) +: 4] = osyndrome[i];
            act_q.push_back(r);
            act_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iclk);
            iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 1'b0;
        end
    endtask

    task automatic beat(input logic s, input logic e, input logic d, input logic [3:0] p,
                        input int gap_pct);
        while (int'($urandom_range(99)) < gap_pct) begin
            @(negedge iclk);
            iclkena = 1'($urandom_range(1));
            ival    = iclkena ? 1'b0 : 1'($urandom_range(1));
            isop    = 1'($urandom_range(1));
            ieop    = 1'($urandom_range(1));
            idat    = 1'($urandom_range(1));
            iptr    = 4'($urandom_range(15));
        end
        @(negedge iclk);
        iclkena = 1'b1; ival = 1'b1; isop = s; ieop = e; idat = d;
        iptr    = s ? p : 4'($urandom_range(15));
    endtask

    task automatic send_frame(input logic [31:0] bits, input int len, input logic [3:0] p,
                              input int gap_pct, input bit with_eop);
        for (int k = 0; k < len; k++)
            beat(k == 0, with_eop && (k == len - 1), bits[len-1-k], p, gap_pct);
    endtask

    task automatic wait_results(input int n, input int budget);
        for (int c = 0; c < budget && act_q.size() < n; c++) begin
            @(negedge iclk);
            #1;
        end
    endtask

    task automatic test_reset();
        ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        idat = 1'b0; iptr = '0;
        repeat (3) @(negedge iclk);
        ireset = 1'b0;
        #1;
        checks++; if (osyndrome_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b want 0", osyndrome_val); end
        checks++; if (osyndrome !== '0) begin errors++; $display("FAIL reset_syn: got %h want 0", osyndrome); end
        checks++; if (osyndrome_ptr !== '0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", osyndrome_ptr); end
        checks++; if (ozero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", ozero); end
        checks++; if (olen_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b want 0", olen_err); end
    endtask

    task automatic test_directed();
        logic [31:0] bits[3] = '{32'h0, 32'h1, 32'h2};
        logic [23:0] syn[3]  = '{24'h000000, 24'h111111, 24'hC63842};
        logic        zero[3] = '{1'b1, 1'b0, 1'b0};
        logic [3:0]  ptr[3]  = '{4'd3, 4'd7, 4'd9};
        for (int c = 0; c < 3; c++) begin
            res_t e, r;
            e.ptr = ptr[c]; e.zero = zero[c]; e.len_err = 1'b0; e.syn = syn[c];
            act_q.delete(); act_cyc.delete();
            send_frame(bits[c], 15, ptr[c], 0, 1);
            idle(1);
            #1;
            checks++; if (osyndrome_val !== 1'b0) begin errors++; $display("FAIL directed[%0d] early_val: got %b want 0", c, osyndrome_val); end
            @(negedge iclk);
            #1;
            checks++; if (osyndrome_val !== 1'b1) begin errors++; $display("FAIL directed[%0d] latency_val: got %b want 1", c, osyndrome_val); end
            checks++;
            if (act_q.size() == 0) begin
                errors++; $display("FAIL directed[%0d] result: got none want %h", c, e);
            end else begin
                r = act_q.pop_front();
                if (r !== e) begin
                    errors++;
                    $display("FAIL directed[%0d] result: got ptr=%0d zero=%b len_err=%b syn=%h want ptr=%0d zero=%b len_err=%b syn=%h",
                             c, r.ptr, r.zero, r.len_err, r.syn, e.ptr, e.zero, e.len_err, e.syn);
                end
            end
            idle(2);
        end
        act_q.delete(); act_cyc.delete();
    endtask

    task automatic test_len_err();
        logic [31:0] b1, b2, b3;
        b1 = $urandom; b2 = $urandom; b3 = $urandom;
        act_q.delete(); act_cyc.delete(); exp_q.delete();
        beat(1'b0, 1'b1, 1'b1, 4'd1, 0);               // stray eop while inactive
        beat(1'b0, 1'b0, 1'b1, 4'd1, 0);               // stray bit while inactive
        send_frame(b1, 14, 4'd11, 0, 1);
        exp_q.push_back(ref_res(b1, 14, 4'd11));
        send_frame(b2, 7, 4'd12, 0, 0);                 // dropped by restart
        send_frame(b3, 15, 4'd13, 0, 1);
        exp_q.push_back(ref_res(b3, 15, 4'd13));
        beat(1'b1, 1'b1, 1'b1, 4'd14, 0);               // length-1 frame
        exp_q.push_back(ref_res(32'h1, 1, 4'd14));
        idle(6);
        wait_results(3, 50);
        checks++;
        if (act_q.size() != 3) begin errors++; $display("FAIL len_err_count: got %0d results want 3", act_q.size()); end
        for (int i = 0; i < 3 && act_q.size() > 0; i++) begin
            res_t r, e;
            r = act_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL len_err[%0d]: got ptr=%0d zero=%b len_err=%b syn=%h want ptr=%0d zero=%b len_err=%b syn=%h",
                         i, r.ptr, r.zero, r.len_err, r.syn, e.ptr, e.zero, e.len_err, e.syn);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b1, b2;
        b1 = $urandom; b2 = $urandom;
        act_q.delete(); act_cyc.delete(); exp_q.delete();
        send_frame(b1, 15, 4'd4, 0, 1);
        send_frame(b2, 15, 4'd5, 0, 1);
        exp_q.push_back(ref_res(b1, 15, 4'd4));
        exp_q.push_back(ref_res(b2, 15, 4'd5));
        idle(3);
        wait_results(2, 50);
        checks++;
        if (act_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d results want 2", act_q.size());
        end else begin
            checks++;
            if (act_cyc[1] - act_cyc[0] != 15) begin
                errors++; $display("FAIL b2b_spacing: got %0d cycles want 15", act_cyc[1] - act_cyc[0]);
            end
        end
        for (int i = 0; i < 2 && act_q.size() > 0; i++) begin
            res_t r, e;
            r = act_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: got ptr=%0d zero=%b len_err=%b syn=%h want ptr=%0d zero=%b len_err=%b syn=%h",
                         i, r.ptr, r.zero, r.len_err, r.syn, e.ptr, e.zero, e.len_err, e.syn);
            end
        end
    endtask

    task automatic test_random();
        int nexp;
        act_q.delete(); act_cyc.delete(); exp_q.delete();
        for (int f = 0; f < 30; f++) begin
            logic [31:0] bits;
            logic [3:0]  p;
            int          len;
            bit          abort;
            bits  = $urandom;
            p     = 4'($urandom_range(15));
            len   = ($urandom_range(3) == 0) ? int'($urandom_range(15, 1)) : 15;
            if ($urandom_range(7) == 0) bits = 32'h0;
            abort = (f < 29) && ($urandom_range(7) == 0);
            send_frame(bits, len, p, 30, !abort);
            if (!abort) exp_q.push_back(ref_res(bits, len, p));
        end
        idle(3);
        nexp = exp_q.size();
        wait_results(nexp, 100);
        checks++;
        if (act_q.size() != nexp) begin errors++; $display("FAIL random_count: got %0d results want %0d", act_q.size(), nexp); end
        for (int i = 0; i < nexp && act_q.size() > 0; i++) begin
            res_t r, e;
            r = act_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL random[%0d]: got ptr=%0d zero=%b len_err=%b syn=%h want ptr=%0d zero=%b len_err=%b syn=%h",
                         i, r.ptr, r.zero, r.len_err, r.syn, e.ptr, e.zero, e.len_err, e.syn);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b;
        res_t        r, e;
        act_q.delete(); act_cyc.delete();
        send_frame($urandom, 7, 4'd6, 0, 0);
        @(negedge iclk);
        ireset = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        @(negedge iclk);
        ireset = 1'b0;
        send_frame($urandom | 32'h1, 15, 4'd8, 0, 1);
        @(negedge iclk);
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; ireset = 1'b1;   // result sits in stage 2
        #1;
        checks++; if (osyndrome_val !== 1'b0 || osyndrome !== '0 || osyndrome_ptr !== '0 || ozero !== 1'b0)
            begin errors++; $display("FAIL reset_mid_outputs: got val=%b syn=%h ptr=%0d zero=%b want all 0", osyndrome_val, osyndrome, osyndrome_ptr, ozero); end
        @(negedge iclk);
        ireset = 1'b0;
        idle(4);
        checks++; if (act_q.size() != 0) begin errors++; $display("FAIL reset_mid_drop: got %0d results want 0", act_q.size()); end
        b = $urandom;
        e = ref_res(b, 15, 4'd10);
        send_frame(b, 15, 4'd10, 0, 1);
        idle(3);
        wait_results(1, 20);
        checks++;
        if (act_q.size() != 1) begin
            errors++; $display("FAIL reset_mid_after: got %0d results want 1", act_q.size());
        end else begin
            r = act_q.pop_front();
            if (r !== e) begin
                errors++;
                $display("FAIL reset_mid_after: got ptr=%0d zero=%b len_err=%b syn=%h want ptr=%0d zero=%b len_err=%b syn=%h",
                         r.ptr, r.zero, r.len_err, r.syn, e.ptr, e.zero, e.len_err, e.syn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_len_err();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
